// File: rtl/vga_block_mapper.sv
// Maps the streamed VGA pixel position to a video-memory cell, linear address and in-cell offset
// using incremental counters. Define VGA_BLOCK_MAPPER_GRID_EN to enable the cell-border overlay.
module vga_block_mapper #(
    parameter int WIDTH_VGA    = 640,
    parameter int HEIGHT_VGA   = 480,
    parameter int WIDTH_MEM    = 16,
    parameter int HEIGHT_MEM   = 12,
    parameter int WIDTH_BLOCK  = 40,
    parameter int HEIGHT_BLOCK = 40,
    parameter int X_BITS       = 10,
    parameter int Y_BITS       = 10,
    parameter int COL_BITS     = 4,
    parameter int ROW_BITS     = 4,
    parameter int ADDR_BITS    = 8,
    parameter int OFF_BITS     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic                 active,
    input  logic [X_BITS-1:0]    vga_x,
    input  logic [Y_BITS-1:0]    vga_y,
    output logic [COL_BITS-1:0]  mem_col,
    output logic [ROW_BITS-1:0]  mem_row,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [OFF_BITS-1:0]  off_x,
    output logic [OFF_BITS-1:0]  off_y,
    output logic                 out_valid,
    output logic                 locked,
    output logic                 grid
);

    localparam logic [OFF_BITS-1:0]  OX_LAST  = OFF_BITS'(WIDTH_BLOCK - 1);
    localparam logic [OFF_BITS-1:0]  OY_LAST  = OFF_BITS'(HEIGHT_BLOCK - 1);
    localparam logic [COL_BITS-1:0]  COL_LAST = COL_BITS'(WIDTH_MEM - 1);
    localparam logic [ROW_BITS-1:0]  ROW_LAST = ROW_BITS'(HEIGHT_MEM - 1);
    localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(WIDTH_MEM);

    if (WIDTH_BLOCK < 2 || HEIGHT_BLOCK < 2 || WIDTH_VGA > (1 << X_BITS) ||
        HEIGHT_VGA > (1 << Y_BITS) || WIDTH_MEM * HEIGHT_MEM > (1 << ADDR_BITS)) begin : g_bad_cfg
        $error("vga_block_mapper: inconsistent parameters");
    end

    logic [X_BITS-1:0]    exp_x, n_exp_x;
    logic [Y_BITS-1:0]    last_y, n_last_y;
    logic [ADDR_BITS-1:0] row_base, n_row_base;
    logic                 h_lock, n_h_lock, v_lock, n_v_lock;
    logic                 col_over, n_col_over, row_over, n_row_over;
    logic [COL_BITS-1:0]  n_col;
    logic [ROW_BITS-1:0]  n_row;
    logic [OFF_BITS-1:0]  n_off_x, n_off_y;
    logic                 n_valid;

    always_comb begin
        n_exp_x    = exp_x;
        n_last_y   = last_y;
        n_row_base = row_base;
        n_h_lock   = h_lock;
        n_v_lock   = v_lock;
        n_col_over = col_over;
        n_row_over = row_over;
        n_col      = mem_col;
        n_row      = mem_row;
        n_off_x    = off_x;
        n_off_y    = off_y;
        n_valid    = 1'b0;
        if (active) begin
            if (vga_x == '0) begin
                n_off_x    = '0;
                n_col      = '0;
                n_col_over = 1'b0;
                n_exp_x    = X_BITS'(1);
                n_h_lock   = 1'b1;
                // Vertical step happens on the line's first pixel so its outputs show the new row.
                n_last_y   = vga_y;
                if (vga_y == '0) begin
                    n_off_y    = '0;
                    n_row      = '0;
                    n_row_base = '0;
                    n_row_over = 1'b0;
                    n_v_lock   = 1'b1;
                end else if (vga_y == last_y + Y_BITS'(1)) begin
                    if (off_y == OY_LAST) begin
                        n_off_y = '0;
                        if (mem_row == ROW_LAST) begin
                            n_row_over = 1'b1;
                        end else begin
                            n_row      = mem_row + ROW_BITS'(1);
                            n_row_base = row_base + ROW_STEP;
                        end
                    end else begin
                        n_off_y = off_y + OFF_BITS'(1);
                    end
                end else begin
                    n_v_lock = 1'b0;
                end
            end else if (vga_x == exp_x) begin
                n_exp_x = exp_x + X_BITS'(1);
                if (off_x == OX_LAST) begin
                    n_off_x = '0;
                    if (mem_col == COL_LAST) n_col_over = 1'b1;
                    else                     n_col = mem_col + COL_BITS'(1);
                end else begin
                    n_off_x = off_x + OFF_BITS'(1);
                end
            end else begin
                n_h_lock = 1'b0;
            end
            n_valid = n_h_lock && n_v_lock && !n_col_over && !n_row_over;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_x     <= '0;
            last_y    <= '1;
            row_base  <= '0;
            h_lock    <= 1'b0;
            v_lock    <= 1'b0;
            col_over  <= 1'b0;
            row_over  <= 1'b0;
            mem_col   <= '0;
            mem_row   <= '0;
            mem_addr  <= '0;
            off_x     <= '0;
            off_y     <= '0;
            out_valid <= 1'b0;
            locked    <= 1'b0;
        end else if (pix_en) begin
            exp_x     <= n_exp_x;
            last_y    <= n_last_y;
            row_base  <= n_row_base;
            h_lock    <= n_h_lock;
            v_lock    <= n_v_lock;
            col_over  <= n_col_over;
            row_over  <= n_row_over;
            mem_col   <= n_col;
            mem_row   <= n_row;
            mem_addr  <= n_row_base + ADDR_BITS'(n_col);
            off_x     <= n_off_x;
            off_y     <= n_off_y;
            out_valid <= n_valid;
            locked    <= n_h_lock && n_v_lock;
        end
    end

`ifdef VGA_BLOCK_MAPPER_GRID_EN
    always_ff @(posedge clk) begin
        if (rst)         grid <= 1'b0;
        else if (pix_en) grid <= n_valid && (n_off_x == '0 || n_off_y == '0);
    end
`else
    assign grid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_block_mapper.sv
// Directed bench for vga_block_mapper: raster segments from a table, each ending in a full output check.
module tb_vga_block_mapper;

    logic       clk = 1'b0;
    logic       rst, pix_en, active;
    logic [9:0] vga_x, vga_y;
    logic [3:0] mem_col, mem_row;
    logic [7:0] mem_addr;
    logic [5:0] off_x, off_y;
    logic       out_valid, locked, grid;

    vga_block_mapper dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .active(active),
        .vga_x(vga_x), .vga_y(vga_y),
        .mem_col(mem_col), .mem_row(mem_row), .mem_addr(mem_addr),
        .off_x(off_x), .off_y(off_y),
        .out_valid(out_valid), .locked(locked), .grid(grid)
    );

    always #5 clk = ~clk;

    // A segment streams lines y0..y1, pixels x0..x1 on each, then checks the outputs.
    typedef struct {
        string name;
        int    y0, y1, x0, x1;
        bit    act, rs;
        int    col, row, addr, ox, oy;
        bit    valid, lock, grd;
    } seg_t;

    seg_t tab[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input string n, input int y0, input int y1, input int x0, input int x1,
                       input bit a, input bit r, input int c, input int rw, input int ad,
                       input int ox, input int oy, input bit v, input bit l, input bit g);
        seg_t s;
        s.name = n; s.y0 = y0; s.y1 = y1; s.x0 = x0; s.x1 = x1; s.act = a; s.rs = r;
        s.col = c; s.row = rw; s.addr = ad; s.ox = ox; s.oy = oy;
        s.valid = v; s.lock = l; s.grd = g;
        tab.push_back(s);
    endtask

    task automatic check(input string what, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", what, got, exp);
        end
    endtask

    task automatic check_all(input string n, input int c, input int rw, input int ad, input int ox,
                             input int oy, input bit v, input bit l, input bit g);
        bit g_exp;
`ifdef VGA_BLOCK_MAPPER_GRID_EN
        g_exp = g;
`else
        g_exp = 1'b0;
`endif
        check({n, ".col"},    int'(mem_col),   c);
        check({n, ".row"},    int'(mem_row),   rw);
        check({n, ".addr"},   int'(mem_addr),  ad);
        check({n, ".off_x"},  int'(off_x),     ox);
        check({n, ".off_y"},  int'(off_y),     oy);
        check({n, ".valid"},  int'(out_valid), int'(v));
        check({n, ".locked"}, int'(locked),    int'(l));
        check({n, ".grid"},   int'(grid),      int'(g_exp));
    endtask

    // One pixel strobe followed by three idle clocks carrying random garbage on the inputs.
    task automatic pix(input int x, input int y, input bit a, input bit r);
        @(negedge clk);
        vga_x  = 10'(x);
        vga_y  = 10'(y);
        active = a;
        rst    = r;
        pix_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            pix_en = 1'b0;
            rst    = 1'b0;
            vga_x  = 10'($urandom_range(0, 1023));
            vga_y  = 10'($urandom_range(0, 1023));
            active = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        //   name          y0   y1   x0   x1  act rst col row addr ox oy val lck grd
        add("p0_0",         0,   0,   0,   0, 1, 0,  0,  0,   0,  0, 0, 1, 1, 1);
        add("p39_0",        0,   0,   1,  39, 1, 0,  0,  0,   0, 39, 0, 1, 1, 1);
        add("p40_0",        0,   0,  40,  40, 1, 0,  1,  0,   1,  0, 0, 1, 1, 1);
        add("p639_0",       0,   0,  41, 639, 1, 0, 15,  0,  15, 39, 0, 1, 1, 1);
        add("blank",        0,   0, 640, 799, 0, 0, 15,  0,  15, 39, 0, 0, 1, 0);
        add("lines1_4",     1,   4,   0,   0, 1, 0,  0,  0,   0,  0, 4, 1, 1, 1);
        add("p100_5",       5,   5,   0, 100, 1, 0,  2,  0,   2, 20, 5, 1, 1, 0);
        add("jump300",      5,   5, 300, 300, 1, 0,  2,  0,   2, 20, 5, 0, 0, 0);
        add("after_jump",   5,   5, 301, 639, 1, 0,  2,  0,   2, 20, 5, 0, 0, 0);
        add("resync0_6",    6,   6,   0,   0, 1, 0,  0,  0,   0,  0, 6, 1, 1, 1);
        add("p40_7",        7,   7,   0,  40, 1, 0,  1,  0,   1,  0, 7, 1, 1, 1);
        add("p0_39",        8,  39,   0,   0, 1, 0,  0,  0,   0,  0,39, 1, 1, 1);
        add("p0_40",       40,  40,   0,   0, 1, 0,  0,  1,  16,  0, 0, 1, 1, 1);
        add("p85_40",      40,  40,   1,  85, 1, 0,  2,  1,  18,  5, 0, 1, 1, 1);
        add("p41_41",      41,  41,   0,  41, 1, 0,  1,  1,  17,  1, 1, 1, 1, 0);
        add("p0_79",       42,  79,   0,   0, 1, 0,  0,  1,  16,  0,39, 1, 1, 1);
        add("p13_80",      80,  80,   0,  13, 1, 0,  0,  2,  32, 13, 0, 1, 1, 1);
        add("p0_478",      81, 478,   0,   0, 1, 0,  0, 11, 176,  0,38, 1, 1, 1);
        add("p639_479",   479, 479,   0, 639, 1, 0, 15, 11, 191, 39,39, 1, 1, 0);
        add("x_clamp",    479, 479, 640, 649, 1, 0, 15, 11, 191,  9,39, 0, 1, 0);
        add("y_clamp",    480, 480,   0,   0, 1, 0,  0, 11, 176,  0, 0, 0, 1, 0);
        add("frame2",       0,   0,   0,   0, 1, 0,  0,  0,   0,  0, 0, 1, 1, 1);
        add("p0_199",       1, 199,   0,   0, 1, 0,  0,  4,  64,  0,39, 1, 1, 1);
        add("p199_200",   200, 200,   0, 199, 1, 0,  4,  5,  84, 39, 0, 1, 1, 1);
        add("rst_200",    200, 200, 200, 200, 1, 1,  0,  0,   0,  0, 0, 0, 0, 0);
        add("post_rst",   200, 200, 201, 639, 1, 0,  0,  0,   0,  0, 0, 0, 0, 0);
        add("line201",    201, 201,   0,  50, 1, 0,  1,  0,   1, 10, 0, 0, 0, 0);
        add("frame3",       0,   0,   0,   0, 1, 0,  0,  0,   0,  0, 0, 1, 1, 1);
        add("frame3_l1",    1,   1,   0,   0, 1, 0,  0,  0,   0,  0, 1, 1, 1, 1);

        // Reset with garbage inputs and pix_en high: everything must come up zero.
        rst    = 1'b1;
        pix_en = 1'b1;
        active = 1'b1;
        vga_x  = 10'd123;
        vga_y  = 10'd45;
        repeat (3) @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // A valid first pixel presented without pix_en must not register.
        rst    = 1'b0;
        pix_en = 1'b0;
        vga_x  = 10'd0;
        vga_y  = 10'd0;
        repeat (2) @(negedge clk);
        check("no_strobe.valid",  int'(out_valid), 0);
        check("no_strobe.locked", int'(locked),    0);

        // First strobed pixel must show up right after its edge.
        @(negedge clk);
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        check("latency.valid", int'(out_valid), 1);

        // Return to reset so the table starts from a clean frame.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        foreach (tab[i]) begin
            for (int y = tab[i].y0; y <= tab[i].y1; y++)
                for (int x = tab[i].x0; x <= tab[i].x1; x++)
                    pix(x, y, tab[i].act, tab[i].rs);
            check_all(tab[i].name, tab[i].col, tab[i].row, tab[i].addr, tab[i].ox, tab[i].oy,
                      tab[i].valid, tab[i].lock, tab[i].grd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
